// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: default widths, the fetch
// FSM state encoding and the prefetch-queue entry layout.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // One buffered instruction: the PC it was fetched from and the word itself.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous clear. The head word is shown
// combinationally on rd_data. A push while full is accepted only when a
// pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: takes PCs from program_counter, issues in-order
// memory requests, buffers returned words and presents them to decode.
// Optional feature macro: IFU_BYPASS_EN (same-cycle response forwarding
// when the queue is empty and decode is ready).
//
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high at the rising edge; valid never depends on ready of the same channel
// (pc_ready is the exception: it is the accept strobe valid&ready). The memory
// response channel has no ready: credit guarantees a queue slot per request.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      pc_in,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  input  logic                   flush,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_W-1:0]      imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [DATA_W-1:0]      imem_rsp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [DATA_W-1:0]      instr_data,
  output logic                   dbg_state,
  output logic [$clog2(DEPTH):0] dbg_drop_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  tag_count;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t      q_head;
  fetch_entry_t      q_wr;
  logic              q_empty;
  logic              credit;
  logic              accept;
  logic              rsp_any;
  logic              rsp_live;
  logic              bypass;
  logic              q_push;
  logic              q_pop;

  // A response slot is reserved for every outstanding request.
  assign credit = ({1'b0, inflight_q} + {1'b0, q_count}) < (CNT_W+1)'(DEPTH);

  // Requests are held off during reset, while draining and on a flush cycle.
  assign imem_req_valid = rst & pc_valid & credit & (state_q == RUN) & ~flush;
  assign imem_req_addr  = {pc_in[ADDR_W-1:2], 2'b00};
  assign accept         = imem_req_valid & imem_req_ready;
  assign pc_ready       = accept;

  // Responses with nothing outstanding are stray and ignored everywhere.
  assign rsp_any  = imem_rsp_valid & (inflight_q != '0);
  assign rsp_live = rsp_any & (tag_count != '0) & (state_q == RUN) & ~flush;

  assign q_empty = (q_count == '0);

`ifdef IFU_BYPASS_EN
  assign bypass = rsp_live & q_empty & instr_ready;
`else
  assign bypass = 1'b0;
`endif

  assign q_push  = rsp_live & ~bypass;
  assign q_pop   = ~q_empty & instr_ready;
  assign q_wr.pc   = tag_head;
  assign q_wr.data = imem_rsp_data;

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (flush),
    .push    (accept),
    .wr_data (pc_in),
    .pop     (rsp_live),
    .rd_data (tag_head),
    .count   (tag_count)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch_q (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (flush),
    .push    (q_push),
    .wr_data (q_wr),
    .pop     (q_pop),
    .rd_data (q_head),
    .count   (q_count)
  );

  // Decode view: queue head first, else a forwarded response, else zeros.
  always_comb begin
    instr_valid = 1'b0;
    instr_pc    = '0;
    instr_data  = '0;
    if (!q_empty) begin
      instr_valid = 1'b1;
      instr_pc    = q_head.pc;
      instr_data  = q_head.data;
    end else if (bypass) begin
      instr_valid = 1'b1;
      instr_pc    = tag_head;
      instr_data  = imem_rsp_data;
    end
  end

  // Outstanding request count: +1 per accept, -1 per counted response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      case ({accept, rsp_any})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // FSM state and stale-response counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: flush re-counts what is still in flight; DRAIN discards
  // responses until that count reaches zero.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (flush) begin
      drop_d  = inflight_q - CNT_W'(rsp_any);
      state_d = (drop_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      if (drop_q == '0) begin
        state_d = RUN;
      end else if (rsp_any) begin
        drop_d = drop_q - CNT_W'(1);
        if (drop_q == CNT_W'(1)) state_d = RUN;
      end
    end
  end

  assign dbg_state    = state_q;
  assign dbg_drop_cnt = drop_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default build, DEPTH=2): a vector
// table of per-cycle inputs and expected outputs, plus hand-written reset
// and streaming sequences checked against an expected-PC queue.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] instr_pc;
  logic [DATA_W-1:0] instr_data;
  logic              dbg_state;
  logic [1:0]        dbg_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_q[$];

  typedef struct {
    logic              fl;
    logic              pv;
    logic [ADDR_W-1:0] pc;
    logic              rr;
    logic              rv;
    logic [DATA_W-1:0] rd;
    logic              ir;
    logic              e_prdy;
    logic              e_rqv;
    logic              e_iv;
    logic [ADDR_W-1:0] e_ipc;
    logic [DATA_W-1:0] e_idat;
    logic              e_st;
    logic [1:0]        e_drop;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_pc       (instr_pc),
    .instr_data     (instr_data),
    .dbg_state      (dbg_state),
    .dbg_drop_cnt   (dbg_drop_cnt)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic fl, pv, input logic [ADDR_W-1:0] pc,
                             input logic rr, rv, input logic [DATA_W-1:0] rd,
                             input logic ir, ep, eq, ei,
                             input logic [ADDR_W-1:0] eipc, input logic [DATA_W-1:0] eidat,
                             input logic es, input logic [1:0] edr);
    vec_t r;
    r.fl = fl; r.pv = pv; r.pc = pc; r.rr = rr; r.rv = rv; r.rd = rd; r.ir = ir;
    r.e_prdy = ep; r.e_rqv = eq; r.e_iv = ei; r.e_ipc = eipc; r.e_idat = eidat;
    r.e_st = es; r.e_drop = edr;
    return r;
  endfunction

  task automatic drive_idle();
    flush = 0; pc_valid = 0; pc_in = '0; imem_req_ready = 1;
    imem_rsp_valid = 0; imem_rsp_data = '0; instr_ready = 1;
  endtask

  task automatic build_table();
    //           fl pv pc      rr rv rd       ir  prdy rqv iv ipc     idat     st drop
    // streaming 0x0,0x4,0x8
    vecs.push_back(v(0,1,'h0,   1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h4,   1,1,'hA0,   1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h8,   1,1,'hA4,   1,  0,0,1,'h0,  'hA0,   0,0));
    vecs.push_back(v(0,1,'h8,   1,0,'h0,    1,  1,1,1,'h4,  'hA4,   0,0));
    vecs.push_back(v(0,0,'h0,   1,1,'hA8,   1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,1,'h8,  'hA8,   0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    // back-pressure from decode
    vecs.push_back(v(0,1,'h20,  1,0,'h0,    0,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h24,  1,1,'hB0,   0,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h28,  1,1,'hB4,   0,  0,0,1,'h20, 'hB0,   0,0));
    vecs.push_back(v(0,1,'h28,  1,0,'h0,    0,  0,0,1,'h20, 'hB0,   0,0));
    vecs.push_back(v(0,1,'h28,  1,0,'h0,    1,  0,0,1,'h20, 'hB0,   0,0));
    vecs.push_back(v(0,1,'h28,  1,0,'h0,    0,  1,1,1,'h24, 'hB4,   0,0));
    vecs.push_back(v(0,0,'h0,   1,1,'hB8,   1,  0,0,1,'h24, 'hB4,   0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,1,'h28, 'hB8,   0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    // flush with two requests outstanding
    vecs.push_back(v(0,1,'h40,  1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h44,  1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(1,1,'h48,  1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h48,  1,1,'hDEAD, 1,  0,0,0,'h0,  'h0,    1,2));
    vecs.push_back(v(0,1,'h48,  1,1,'hBEEF, 1,  0,0,0,'h0,  'h0,    1,1));
    vecs.push_back(v(0,1,'h100, 1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,1,'hC100, 1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,1,'h100,'hC100, 0,0));
    // flush coincident with a response
    vecs.push_back(v(0,1,'h200, 1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h204, 1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(1,0,'h0,   1,1,'hD0,   1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h300, 1,0,'h0,    1,  0,0,0,'h0,  'h0,    1,1));
    vecs.push_back(v(0,0,'h0,   1,1,'hD4,   1,  0,0,0,'h0,  'h0,    1,1));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    // unaligned PC
    vecs.push_back(v(0,1,'h13,  1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,1,'hE13,  1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,1,'h13, 'hE13,  0,0));
    // stray response with nothing in flight, then an idle flush
    vecs.push_back(v(0,0,'h0,   1,1,'hFF,   1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(1,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    // memory not ready holds the request
    vecs.push_back(v(0,1,'h50,  0,0,'h0,    1,  0,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h50,  1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,1,'h5050, 1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,1,'h50, 'h5050, 0,0));
    // flush during DRAIN re-counts from inflight
    vecs.push_back(v(0,1,'h70,  1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,1,'h74,  1,0,'h0,    1,  1,1,0,'h0,  'h0,    0,0));
    vecs.push_back(v(1,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
    vecs.push_back(v(0,0,'h0,   1,1,'h70,   1,  0,0,0,'h0,  'h0,    1,2));
    vecs.push_back(v(1,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    1,1));
    vecs.push_back(v(0,0,'h0,   1,1,'h74,   1,  0,0,0,'h0,  'h0,    1,1));
    vecs.push_back(v(0,0,'h0,   1,0,'h0,    1,  0,0,0,'h0,  'h0,    0,0));
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(negedge clk);
      flush = vecs[i].fl; pc_valid = vecs[i].pv; pc_in = vecs[i].pc;
      imem_req_ready = vecs[i].rr; imem_rsp_valid = vecs[i].rv;
      imem_rsp_data = vecs[i].rd; instr_ready = vecs[i].ir;
      #1;
      chk($sformatf("v%0d pc_ready", i), 64'(pc_ready), 64'(vecs[i].e_prdy));
      chk($sformatf("v%0d req_valid", i), 64'(imem_req_valid), 64'(vecs[i].e_rqv));
      if (vecs[i].e_rqv)
        chk($sformatf("v%0d req_addr", i), 64'(imem_req_addr), 64'(vecs[i].pc & ~32'h3));
      chk($sformatf("v%0d instr_valid", i), 64'(instr_valid), 64'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d instr_pc", i), 64'(instr_pc), 64'(vecs[i].e_ipc));
        chk($sformatf("v%0d instr_data", i), 64'(instr_data), 64'(vecs[i].e_idat));
      end
      chk($sformatf("v%0d state", i), 64'(dbg_state), 64'(vecs[i].e_st));
      chk($sformatf("v%0d drop_cnt", i), 64'(dbg_drop_cnt), 64'(vecs[i].e_drop));
    end
  endtask

  // Streaming driver with a 1-cycle memory responder and expected-PC queue.
  task automatic run_stream(input int n);
    int sent = 0;
    int cycles = 0;
    logic have_rsp = 0;
    logic [ADDR_W-1:0] rsp_pc = '0;
    logic acc;
    while ((sent < n || exp_q.size() != 0 || have_rsp) && cycles < 200) begin
      @(negedge clk);
      cycles++;
      flush = 0; imem_req_ready = 1; instr_ready = 1;
      imem_rsp_valid = have_rsp;
      imem_rsp_data  = have_rsp ? (rsp_pc ^ 32'h5A5A_0000) : '0;
      pc_valid = (sent < n);
      pc_in    = ADDR_W'(sent * 4);
      #1;
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream unexpected instr", 64'(instr_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [ADDR_W-1:0] e;
          e = exp_q.pop_front();
          chk("stream instr_pc", 64'(instr_pc), 64'(e));
          chk("stream instr_data", 64'(instr_data), 64'(e ^ 32'h5A5A_0000));
        end
      end
      acc = pc_ready;
      if (acc) begin
        exp_q.push_back(pc_in);
        sent++;
      end
      have_rsp = acc;
      rsp_pc   = pc_in;
    end
    chk("stream completed in budget", 64'(cycles < 200), 64'd1);
    chk("stream all delivered", 64'(sent), 64'(n));
  endtask

  // Main sequence
  initial begin
    rst = 1'b0;
    drive_idle();
    pc_valid = 1; pc_in = 'h44;
    build_table();
    repeat (2) @(negedge clk);
    #1;
    chk("reset req_valid", 64'(imem_req_valid), 64'd0);
    chk("reset pc_ready", 64'(pc_ready), 64'd0);
    chk("reset instr_valid", 64'(instr_valid), 64'd0);
    chk("reset instr_pc", 64'(instr_pc), 64'd0);
    chk("reset instr_data", 64'(instr_data), 64'd0);
    chk("reset state", 64'(dbg_state), 64'd0);
    chk("reset drop_cnt", 64'(dbg_drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();

    run_table();

    // Reset with two queued entries
    @(negedge clk);
    drive_idle(); instr_ready = 0; pc_valid = 1; pc_in = 'h60;
    @(negedge clk);
    pc_in = 'h64; imem_rsp_valid = 1; imem_rsp_data = 'h6060;
    @(negedge clk);
    pc_valid = 0; imem_rsp_valid = 1; imem_rsp_data = 'h6464;
    @(negedge clk);
    imem_rsp_valid = 0; pc_valid = 1; pc_in = 'h68;
    #1;
    chk("full q instr_valid", 64'(instr_valid), 64'd1);
    chk("full q instr_pc", 64'(instr_pc), 64'h60);
    chk("full q pc_ready", 64'(pc_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset instr_valid", 64'(instr_valid), 64'd0);
    chk("async reset instr_pc", 64'(instr_pc), 64'd0);
    chk("async reset req_valid", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;

    run_stream(6);

    @(negedge clk);
    drive_idle();
    #1;
    chk("end instr_valid", 64'(instr_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
